// File: rtl/alu_result_display.sv
// alu_result_display
// Captures a 6-bit ALU result on an update pulse, converts it to sign plus
// two BCD digits with a sequential double-dabble, and continuously scans the
// four-digit active-low seven-segment display.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for update; display shows last committed value
// SHIFT  | six double-dabble shift steps on {bcd, mag}
// COMMIT | copy converted digits into the display registers
module alu_result_display #(
  parameter int CNT_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] result,
  input  logic       is_signed,
  input  logic       update,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  state_t state, state_nxt;

  // conversion working registers
  logic       neg;
  logic [5:0] mag;
  logic [7:0] bcd;
  logic [2:0] shift_cnt;

  // committed display registers
  logic       disp_neg;
  logic       disp_tens_blank;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;

  // refresh scan
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel;

  // control strobes from the output decode
  logic do_capture;
  logic do_shift;
  logic do_commit;

  // datapath helpers
  logic [5:0] twos_mag;
  logic [7:0] bcd_adj;
  logic [3:0] nib_hi_adj;
  logic [3:0] nib_lo_adj;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    code = SEG_BLANK;
    case (digit)
      4'd0: code = 7'b1000000;
      4'd1: code = 7'b1111001;
      4'd2: code = 7'b0100100;
      4'd3: code = 7'b0110000;
      4'd4: code = 7'b0011001;
      4'd5: code = 7'b0010010;
      4'd6: code = 7'b0000010;
      4'd7: code = 7'b1111000;
      4'd8: code = 7'b0000000;
      4'd9: code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; shift_cnt==5 marks the sixth and final shift edge
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (update) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_cnt == 3'd5) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: per-state strobes that drive the registered datapath
  always_comb begin
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      S_IDLE:   do_capture = update;
      S_SHIFT:  do_shift   = 1'b1;
      S_COMMIT: do_commit  = 1'b1;
      default: begin
        do_capture = 1'b0;
      end
    endcase
  end

  // Double-dabble adjust: any BCD nibble of 5 or more gets +3 before shifting
  always_comb begin
    twos_mag   = (~result) + 6'd1;
    nib_lo_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    nib_hi_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    bcd_adj    = {nib_hi_adj, nib_lo_adj};
  end

  // Conversion datapath and busy flag; 6'b100000 signed negates to 32, which fits
  always_ff @(posedge clk) begin
    if (rst) begin
      neg             <= 1'b0;
      mag             <= 6'd0;
      bcd             <= 8'h00;
      shift_cnt       <= 3'd0;
      busy            <= 1'b0;
      disp_neg        <= 1'b0;
      disp_tens_blank <= 1'b1;
      disp_tens       <= 4'd0;
      disp_ones       <= 4'd0;
    end else if (do_capture) begin
      if (is_signed && result[5]) begin
        neg <= 1'b1;
        mag <= twos_mag;
      end else begin
        neg <= 1'b0;
        mag <= result;
      end
      bcd       <= 8'h00;
      shift_cnt <= 3'd0;
      busy      <= 1'b1;
    end else if (do_shift) begin
      {bcd, mag} <= {bcd_adj, mag} << 1;
      shift_cnt  <= shift_cnt + 3'd1;
    end else if (do_commit) begin
      disp_neg        <= neg;
      disp_tens       <= bcd[7:4];
      disp_ones       <= bcd[3:0];
      disp_tens_blank <= (bcd[7:4] == 4'd0);
      busy            <= 1'b0;
    end
  end

  // Free-running refresh counter; top two bits pick the digit slot
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sel = cnt[CNT_W-1 -: 2];

  // Digit mux: slot 3 is never lit; leading zero and positive sign are blanked
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    case (sel)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = seg_code(disp_ones);
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = disp_tens_blank ? SEG_BLANK : seg_code(disp_tens);
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = disp_neg ? SEG_MINUS : SEG_BLANK;
      end
      default: begin
        an_nxt  = 4'b1111;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

  // Registered pin drivers; seg/an lag the slot select by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Testbench for alu_result_display with a short refresh counter.
module tb_alu_result_display;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] result = 6'd0;
  logic       is_signed = 1'b0;
  logic       update = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  alu_result_display #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .result(result), .is_signed(is_signed),
    .update(update), .busy(busy), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Reference: interpret the value, take magnitude, split into decimal digits.
  function automatic void model(input logic [5:0] r, input logic s,
                                output logic [6:0] e0, output logic [6:0] e1,
                                output logic [6:0] e2);
    int v;
    int m;
    v = int'(r);
    if (s && v >= 32) v = v - 64;
    m = (v < 0) ? -v : v;
    e0 = segtab[m % 10];
    e1 = (m >= 10) ? segtab[m / 10] : 7'b1111111;
    e2 = (v < 0) ? 7'b0111111 : 7'b1111111;
  endfunction

  // Observe one full scan; records seg seen per anode pattern.
  task automatic scan_display(output logic [27:0] seen, output int bad_an, output int bad_dp);
    logic [6:0] s0, s1, s2, s3;
    s0 = 7'bx; s1 = 7'bx; s2 = 7'bx; s3 = 7'bx;
    bad_an = 0; bad_dp = 0;
    repeat (20) begin
      @(negedge clk);
      case (an)
        4'b1110: s0 = seg;
        4'b1101: s1 = seg;
        4'b1011: s2 = seg;
        4'b1111: s3 = seg;
        default: bad_an++;
      endcase
      if (dp !== 1'b1) bad_dp++;
    end
    seen = {s0, s1, s2, s3};
  endtask

  // Pulse update for one cycle; returns at the negedge after the capture edge.
  task automatic start_update(input logic [5:0] r, input logic s);
    @(negedge clk);
    result = r; is_signed = s; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    result = 6'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int slot;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0 || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state an=%b seg=%b busy=%b dp=%b exp an=1111 seg=1111111 busy=0 dp=1",
               an, seg, busy, dp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      slot = ((k - 1) >> 2) & 3;
      case (slot)
        0: begin exp_an = 4'b1110; exp_seg = 7'b1000000; end
        1: begin exp_an = 4'b1101; exp_seg = 7'b1111111; end
        2: begin exp_an = 4'b1011; exp_seg = 7'b1111111; end
        default: begin exp_an = 4'b1111; exp_seg = 7'b1111111; end
      endcase
      vectors++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        miscompares++;
        $display("FAIL scan_after_reset k=%0d an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                 k, an, seg, dp, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_value(input string name, input logic [5:0] r, input logic s);
    int n, bad_an, bad_dp;
    logic [27:0] seen;
    logic [6:0] e0, e1, e2;
    start_update(r, s);
    wait_idle(n);
    vectors++;
    if (n != 7) begin
      miscompares++;
      $display("FAIL %s busy_len got=%0d exp=7", name, n);
    end
    model(r, s, e0, e1, e2);
    scan_display(seen, bad_an, bad_dp);
    vectors++;
    if (seen !== {e0, e1, e2, 7'b1111111} || bad_an != 0 || bad_dp != 0) begin
      miscompares++;
      $display("FAIL %s display r=%b s=%b got=%h exp=%h bad_an=%0d bad_dp=%0d",
               name, r, s, seen, {e0, e1, e2, 7'b1111111}, bad_an, bad_dp);
    end
  endtask

  task automatic test_busy_ignore();
    int n, bad_an, bad_dp;
    logic [27:0] seen;
    logic [6:0] e0, e1, e2;
    start_update(6'd63, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 3) begin
        update = 1'b1; result = 6'd5; is_signed = 1'b0;
      end else begin
        update = 1'b0;
      end
      @(negedge clk);
    end
    update = 1'b0;
    vectors++;
    if (n != 7) begin
      miscompares++;
      $display("FAIL busy_ignore busy_len got=%0d exp=7", n);
    end
    model(6'd63, 1'b0, e0, e1, e2);
    scan_display(seen, bad_an, bad_dp);
    vectors++;
    if (seen !== {e0, e1, e2, 7'b1111111} || bad_an != 0) begin
      miscompares++;
      $display("FAIL busy_ignore display got=%h exp=%h", seen, {e0, e1, e2, 7'b1111111});
    end
    test_value("after_ignore_5", 6'd5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, bad_an, bad_dp;
    logic [27:0] seen;
    logic [6:0] e0, e1, e2;
    logic [5:0] a;
    logic sa;
    a = 6'($urandom);
    sa = 1'($urandom);
    start_update(a, sa);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 7) begin
        update = 1'b1; result = a ^ 6'h2a; is_signed = ~sa;
      end else begin
        update = 1'b0;
      end
      @(negedge clk);
    end
    update = 1'b0;
    @(negedge clk);
    vectors++;
    if (n != 7 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back busy_len=%0d busy_after=%b exp 7 and 0", n, busy);
    end
    model(a, sa, e0, e1, e2);
    scan_display(seen, bad_an, bad_dp);
    vectors++;
    if (seen !== {e0, e1, e2, 7'b1111111} || bad_an != 0) begin
      miscompares++;
      $display("FAIL back_to_back display got=%h exp=%h", seen, {e0, e1, e2, 7'b1111111});
    end
  endtask

  task automatic test_reset_midconv();
    int n, bad_an, bad_dp;
    logic [27:0] seen;
    logic [6:0] e0, e1, e2;
    start_update(6'd47, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midconv busy got=%b exp=0", busy);
    end
    rst = 1'b0;
    model(6'd0, 1'b0, e0, e1, e2);
    scan_display(seen, bad_an, bad_dp);
    vectors++;
    if (seen !== {e0, e1, e2, 7'b1111111} || bad_an != 0) begin
      miscompares++;
      $display("FAIL reset_midconv display got=%h exp=%h", seen, {e0, e1, e2, 7'b1111111});
    end
    start_update(6'd47, 1'b0);
    wait_idle(n);
    scan_display(seen, bad_an, bad_dp);
    vectors++;
    if (seen[20:14] !== 7'b0011001 || seen[27:21] !== 7'b1111000 || seen[13:7] !== 7'b1111111) begin
      miscompares++;
      $display("FAIL reset_midconv_47 got=%h exp tens=0011001 ones=1111000 sign blank", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_value("random", 6'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_value("unsigned_63", 6'd63, 1'b0);
    test_value("signed_m32", 6'b100000, 1'b1);
    test_value("signed_m5", 6'b111011, 1'b1);
    test_value("unsigned_32", 6'b100000, 1'b0);
    test_value("signed_0", 6'd0, 1'b1);
    test_busy_ignore();
    test_back_to_back();
    test_reset_midconv();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Output-side counterpart to the ALU operand path: switches feed operands in, and this block takes the 6-bit ALU result out to the Basys 3 four-digit seven-segment display.
- On an update pulse it captures the result and converts it to sign + two BCD digits with a sequential double-dabble FSM.
- It continuously time-multiplexes the display anodes.
- It sits between the ALU result bus and the top-level seg/an/dp pins.

Parameters:
- CNT_W, 18, refresh counter width; digit select = cnt[CNT_W-1:CNT_W-2]. 18 at 100 MHz gives a ~381 Hz full scan. Benches use 4.

Ports:
- clk  input  1  system clock (100 MHz on board)
- rst  input  1  synchronous, active-high reset
- result  input  6  ALU result to display
- is_signed  input  1  1 = treat result as two's complement (-32..31); 0 = unsigned (0..63)
- update  input  1  single-cycle request to capture and display result
- busy  output  1  conversion in progress; update ignored while high
- seg  output  7  active-low segments, seg[0]=a … seg[6]=g
- dp  output  1  active-low decimal point, held 1 (off)
- an  output  4  active-low anodes, an[0]=rightmost digit

Behaviour:
- All outputs registered. During any cycle with rst sampled high:
  - an←4'b1111, seg←7'b1111111, dp←1, busy←0, cnt←0, FSM←IDLE.
  - Display regs: sign_neg←0, tens_blank←1, ones←0, so the display shows "0".
- Capture, at an edge with state IDLE and update=1:
  - If is_signed && result[5]: neg←1, mag←(~result+1) as 6-bit unsigned. 6'b100000 gives mag=32, which fits.
  - Else neg←0, mag←result.
  - bcd←8'h00, shift count←0, busy←1, state←SHIFT.
- SHIFT, exactly 6 edges:
  - Each edge: add 3 to any BCD nibble ≥5, then shift {bcd,mag} left by 1.
  - After the 6th shift, state←COMMIT.
- COMMIT, 1 edge:
  - Display regs←{neg, tens, ones}; tens_blank←(tens==0).
  - busy←0, state←IDLE.
- Latency: update sampled at edge E0; busy high after E0 through E7 (7 cycles); display regs updated at E7.
- update while busy (SHIFT/COMMIT) is ignored: not queued, and captured values are not disturbed.
- update on the same edge busy falls is also ignored. A new capture needs update high with state IDLE.
- Result/is_signed changes after capture have no effect until the next accepted update.
- Refresh: cnt increments every cycle and wraps mod 2^CNT_W.
- Digit mapping by select, registered one cycle (seg/an reflect the select value of the previous cycle):
  - 0: an=1110, ones digit.
  - 1: an=1101, tens digit, or blank (1111111) if tens_blank.
  - 2: an=1011, '-' (0111111) if sign_neg, else blank.
  - 3: an=1111 (digit unused, never lit), seg=1111111.
- Segment codes, g..a active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Exactly one anode low in slots 0–2; none in slot 3. dp always 1.
- Reset mid-conversion: aborts to IDLE with reset display values; the pending result is discarded.
- Unsigned 6'b100000 displays "32" with no sign. Signed 0 displays "0" with no sign.

Test Plan:
1. Reset (CNT_W=4), release, run 64 cycles:
   - an cycles 1110→1101→1011→1111.
   - Slot 0 seg=1000000; other slots blank; an[3] never 0; dp=1.
2. is_signed=0, result=6'd63, update 1 cycle:
   - busy high exactly 7 cycles.
   - Then an=1110 seg=0110000 ("3"), an=1101 seg=0000010 ("6"), an=1011 blank.
3. is_signed=1, result=6'b100000:
   - Display "-32": slot 2 seg=0111111, tens 0110000, ones 0100100.
4. is_signed=1, result=6'b111011 (-5):
   - Slot 2 '-' 0111111, tens blank 1111111, ones 0010010.
5. Show 63, then update with result=5 on the 3rd busy cycle:
   - Ignored; busy still falls after 7 cycles; display stays "63".
   - A subsequent update with busy=0 displays "5".
6. Assert rst at the 4th SHIFT cycle of a conversion of 6'd47:
   - busy=0 next cycle; display returns to "0".
   - A later update with result=47 displays "47" (tens 0011001, ones 1111000).
